ram_two_arbiter: RTL

//  Shares one two-port RAM (ram_two_async, both clocks tied to clk_i) between NumReq requesters.

---
 rtl/ram_arb_pkg.sv | 34 +++
 rtl/ram_two_arbiter_rr_pick.sv | 56 +++++
 rtl/ram_two_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb_pkg
//  Description : Shared types and helper functions for the two-port RAM
//                arbiter (one-hot grant vectors, index conversion, pointer
//                advance).
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    // Upper bound on requester count carried by the generic one-hot type.
    localparam int unsigned c_MAX_REQ = 32;

    typedef logic [c_MAX_REQ-1:0] onehot_t;

    // Index of the set bit in a one-hot vector (0 when the vector is empty).
    function automatic int unsigned onehot_to_idx(input onehot_t i_vec);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < c_MAX_REQ; i++) begin
            if (i_vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    // Round-robin successor of a winner index, wrapping n-1 -> 0.
    function automatic int unsigned rr_next(input int unsigned i_idx, input int unsigned i_n);
        return ((i_idx + 1) >= i_n) ? 0 : (i_idx + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_two_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Picks the lowest
//                candidate index at or above the pointer, wrapping to 0.
//                The pointer itself is owned by the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_cand,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [2*NUM_REQ-1:0] w_rot;
    logic [2*NUM_REQ-1:0] w_gdbl;
    logic [NUM_REQ-1:0]   w_rel;
    logic [NUM_REQ-1:0]   w_grant;
    onehot_t              w_grant_ext;
    logic                 w_found;

    // Rotate candidates so the pointer position sits at bit 0, take the first
    // set bit, then rotate the one-hot result back into absolute position.
    always_comb begin
        w_rot   = {i_cand, i_cand} >> i_ptr;
        w_rel   = '0;
        w_found = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!w_found && w_rot[off]) begin
                w_found    = 1'b1;
                w_rel[off] = 1'b1;
            end
        end
        w_gdbl  = {{NUM_REQ{1'b0}}, w_rel} << i_ptr;
        w_grant = w_gdbl[NUM_REQ-1:0] | w_gdbl[2*NUM_REQ-1:NUM_REQ];
    end

    // Widen the grant to the package one-hot type for index conversion.
    always_comb begin
        w_grant_ext                = '0;
        w_grant_ext[NUM_REQ-1:0]   = w_grant;
    end

    assign o_grant = w_grant;
    assign o_idx   = IDX_W'(onehot_to_idx(w_grant_ext));
    assign o_any   = w_found;

endmodule
`default_nettype wire

// File: rtl/ram_two_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_two_arbiter
//  Description : Shares one two-port RAM between NUM_REQ requesters. Read
//                and write ports are arbitrated independently (round-robin),
//                same-address read/write collisions defer the read by a
//                cycle, and read data returns with a registered owner tag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_two_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ-1:0]          req_we_i,
    input  logic [NUM_REQ*$clog2(DEPTH)-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]    req_wdata_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    output logic [WIDTH-1:0]            rsp_data_o,
    output logic                        ram_we_o,
    output logic [$clog2(DEPTH)-1:0]    ram_waddr_o,
    output logic [WIDTH-1:0]            ram_wdata_o,
    output logic                        ram_re_o,
    output logic [$clog2(DEPTH)-1:0]    ram_raddr_o,
    input  logic [WIDTH-1:0]            ram_rdata_i
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_IW = $clog2(NUM_REQ);

    logic [c_IW-1:0]    r_wptr;
    logic [c_IW-1:0]    r_rptr;
    logic [NUM_REQ-1:0] r_rsp_tag;

    logic [NUM_REQ-1:0] w_wcand;
    logic [NUM_REQ-1:0] w_rcand;
    logic [NUM_REQ-1:0] w_wgrant;
    logic [NUM_REQ-1:0] w_rgrant;
    logic [c_IW-1:0]    w_widx;
    logic [c_IW-1:0]    w_ridx;
    logic               w_wany;
    logic               w_rany;
    logic [c_AW-1:0]    w_waddr;
    logic [WIDTH-1:0]   w_wdata;
    logic [c_AW-1:0]    w_raddr;
    logic               w_collision;
    logic               w_rgo;

    // Candidates are masked during reset so nothing is granted or issued.
    assign w_wcand = req_valid_i &  req_we_i & {NUM_REQ{~rst_i}};
    assign w_rcand = req_valid_i & ~req_we_i & {NUM_REQ{~rst_i}};

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IW)
    ) u_wpick (
        .i_cand  (w_wcand),
        .i_ptr   (r_wptr),
        .o_grant (w_wgrant),
        .o_idx   (w_widx),
        .o_any   (w_wany)
    );

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IW)
    ) u_rpick (
        .i_cand  (w_rcand),
        .i_ptr   (r_rptr),
        .o_grant (w_rgrant),
        .o_idx   (w_ridx),
        .o_any   (w_rany)
    );

    // One-hot AND-OR payload muxes for the write and read winners.
    always_comb begin
        w_waddr = '0;
        w_wdata = '0;
        w_raddr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_wgrant[i]) begin
                w_waddr = req_addr_i[i*c_AW +: c_AW];
                w_wdata = req_wdata_i[i*WIDTH +: WIDTH];
            end
            if (w_rgrant[i]) begin
                w_raddr = req_addr_i[i*c_AW +: c_AW];
            end
        end
    end

    // A read hitting this cycle's write address waits so it returns new data.
    assign w_collision = w_wany & w_rany & (w_waddr == w_raddr);
    assign w_rgo       = w_rany & ~w_collision;

    assign req_ready_o = w_wgrant | (w_rgrant & {NUM_REQ{w_rgo}});
    assign ram_we_o    = w_wany;
    assign ram_waddr_o = w_waddr;
    assign ram_wdata_o = w_wdata;
    assign ram_re_o    = w_rgo;
    assign ram_raddr_o = w_raddr;

    // Round-robin pointers advance past the winner only when a grant is made.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wany) begin
                r_wptr <= c_IW'(rr_next(32'(w_widx), NUM_REQ));
            end
            if (w_rgo) begin
                r_rptr <= c_IW'(rr_next(32'(w_ridx), NUM_REQ));
            end
        end
    end

    // Owner tag for the read issued at this edge; its data appears next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_tag <= '0;
        end else begin
            r_rsp_tag <= w_rgo ? w_rgrant : '0;
        end
    end

    // Asserting reset also kills a response that is being presented.
    assign rsp_valid_o = r_rsp_tag & {NUM_REQ{~rst_i}};
    assign rsp_data_o  = ram_rdata_i;

endmodule
`default_nettype wire
